phone_char_feeder: RTL and testbench
====================================

PHONE_CHAR_FEEDER -- requirements
Module: phone_char_feeder

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..16).
REQ-002 The block SHALL have the parameter GAP, default 2, meaning the minimum cycles between consecutive send pulses (GAP >= 2).
REQ-003 The port clk SHALL be an input, 1 bit wide, and is the single rising-edge clock.
REQ-004 The port rst SHALL be an input, 1 bit wide, and is the synchronous, active-low reset.
REQ-005 The port callActive SHALL be an input, 1 bit wide, and is high while the downstream call is in the talking state.
REQ-006 The port keyValid SHALL be an input, 1 bit wide, and is a one-cycle push strobe.
REQ-007 The port keyChar SHALL be an input, 8 bits wide, and is the ASCII character to push.
REQ-008 The port keySide SHALL be an input, 1 bit wide, and selects the sender (0 = caller, 1 = callee).
REQ-009 The port sendCharCaller SHALL be an output, 1 bit wide, and is a one-cycle send pulse for the caller.
REQ-010 The port sendCharCallee SHALL be an output, 1 bit wide, and is a one-cycle send pulse for the callee.
REQ-011 The port charSent SHALL be an output, 8 bits wide, and is the character accompanying the pulse.
REQ-012 The port count SHALL be an output, clog2(DEPTH)+1 bits wide, and is the current queue occupancy.
REQ-013 The port full SHALL be an output, 1 bit wide, and is high when count == DEPTH.
REQ-014 The port empty SHALL be an output, 1 bit wide, and is high when count == 0.
REQ-015 The port dropCount SHALL be an output, 8 bits wide, and is a saturating count of rejected pushes.

Function
REQ-016 The queue SHALL store 9-bit entries of the form {keySide, keyChar} in FIFO order.
REQ-017 A push SHALL be accepted only when keyValid=1, callActive=1, keyChar is within 0x20..0x7E, and the queue is not full (or a pop occurs in the same cycle).
REQ-018 A push with keyValid=1 and callActive=1 that is rejected (full with no pop, or non-printable) SHALL increment dropCount, saturating at 255.
REQ-019 A push with callActive=0 SHALL be ignored and SHALL NOT be counted.
REQ-020 The FSM SHALL have the states IDLE, READY and WAIT.
REQ-021 In IDLE, when callActive=1, the FSM SHALL go to READY.
REQ-022 In READY, when the queue is non-empty, the head SHALL be popped and the FSM SHALL go to WAIT, loading the gap counter with GAP-1.
REQ-023 On the clock edge that pops an entry, the pulse selected by the entry's side bit SHALL be registered high for exactly one cycle.
REQ-024 On that same edge, charSent SHALL be registered with the entry's character.
REQ-025 In WAIT, the gap counter SHALL decrement each cycle, and the FSM SHALL go to READY when it reaches 0.
REQ-026 Send pulses SHALL therefore be separated by at least GAP-1 low cycles.
REQ-027 sendCharCaller and sendCharCallee SHALL never be high in the same cycle.
REQ-028 charSent SHALL hold its last value between pulses.
REQ-029 There SHALL be no same-cycle bypass: a push into an empty queue while in READY produces its pulse in the second cycle after the push cycle.
REQ-030 When callActive=0 in any state, on the next edge the FSM SHALL go to IDLE, count SHALL be cleared to 0, and no pulse SHALL be issued.
REQ-031 On a flush, dropCount and charSent SHALL be retained.
REQ-032 A simultaneous push and pop when full SHALL be accepted, leaving count unchanged.
REQ-033 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-034 While rst=0 at a rising clk edge, the FSM SHALL go to IDLE, pointers and count SHALL be set to 0, both pulses SHALL be 0, charSent SHALL be 8'h00, dropCount SHALL be 0, empty SHALL be 1, and full SHALL be 0.
REQ-035 Reset SHALL take priority over all other inputs, including a push in the same cycle.
REQ-036 A reset asserted mid-transfer SHALL discard all queued entries.

Verification
REQ-037 The bench SHALL cover: reset, then callActive=1, then push 'H' (0x48) with side 0 -> a single sendCharCaller pulse with charSent=0x48 two cycles after the push, and count returns to 0.
REQ-038 The bench SHALL cover: push 'A','B','C' on consecutive cycles with GAP=2 -> pulses on cycles t+2, t+4 and t+6, with charSent 0x41, 0x42 and 0x43.
REQ-039 The bench SHALL cover: push 6 keys back-to-back while the FSM is in WAIT (DEPTH=4) -> full=1 and the pushes that meet a full queue without a pop are rejected and counted in dropCount.
REQ-040 The bench SHALL cover: push 0x0A, and separately push 'x' with callActive=0 -> dropCount +1 for the first only, and no pulse for either.
REQ-041 The bench SHALL cover: 3 entries queued, then callActive drops -> the next edge gives IDLE, count=0, empty=1, and no further pulses after callActive returns high.
REQ-042 The bench SHALL cover: alternating sides 'a'(0), 'b'(1) -> the pulses alternate between caller and callee and never overlap.

Source files
------------

// File: rtl/phone_char_feeder.sv
// Character feeder for a phone call: queues printable keys per side and
// releases them as one-cycle send pulses spaced at least GAP cycles apart.
module phone_char_feeder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned GAP   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      callActive,
   input  logic                      keyValid,
   input  logic [7:0]                keyChar,
   input  logic                      keySide,
   output logic                      sendCharCaller,
   output logic                      sendCharCallee,
   output logic [7:0]                charSent,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty,
   output logic [7:0]                dropCount
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned GW = $clog2(GAP);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);

   typedef enum logic [1:0] {IDLE, READY, WAIT} state_t;

   state_t          state, state_next;
   logic [GW-1:0]   gap_cnt, gap_next;
   logic [8:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [8:0]      head;
   logic            printable, push, pop, drop;

   always_comb begin
      printable = (keyChar >= 8'h20) && (keyChar <= 8'h7E);
      full      = (count == DEPTH_CNT);
      empty     = (count == '0);
      head      = mem[rd_ptr];
      pop       = (state == READY) && !empty && callActive;
      // A pop in the same cycle frees a slot, so a full queue still accepts.
      push      = keyValid && callActive && printable && (!full || pop);
      drop      = keyValid && callActive && !push;
   end

   always_comb begin
      state_next = state;
      gap_next   = gap_cnt;
      if (!callActive) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:  state_next = READY;
            READY: begin
               if (!empty) begin
                  state_next = WAIT;
                  gap_next   = GAP_LOAD;
               end
            end
            WAIT: begin
               if (gap_cnt <= GW'(1)) state_next = READY;
               else                   gap_next   = gap_cnt - GW'(1);
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push) mem[wr_ptr] <= {keySide, keyChar};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         gap_cnt        <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         sendCharCaller <= 1'b0;
         sendCharCallee <= 1'b0;
         charSent       <= '0;
         dropCount      <= '0;
      end else begin
         state          <= state_next;
         gap_cnt        <= gap_next;
         sendCharCaller <= pop && !head[8];
         sendCharCallee <= pop && head[8];
         if (pop) charSent <= head[7:0];
         if (drop && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
         // Dropping the call flushes the queue but keeps charSent and dropCount.
         if (!callActive) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW + 1)'(1);
            else if (pop && !push) count <= count - (AW + 1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_phone_char_feeder.sv
// Bench for phone_char_feeder: a GAP=2 and a GAP=8 instance share stimulus;
// expected pulses go to a scoreboard and are matched as the DUT emits them.
module tb_phone_char_feeder;

   logic       clk = 1'b0;
   logic       rst, callActive, keyValid, keySide;
   logic [7:0] keyChar;

   logic       a_caller, a_callee, a_full, a_empty;
   logic [7:0] a_char, a_drop;
   logic [2:0] a_count;
   logic       b_caller, b_callee, b_full, b_empty;
   logic [7:0] b_char, b_drop;
   logic [2:0] b_count;

   always #5 clk = ~clk;

   phone_char_feeder #(.DEPTH(4), .GAP(2)) dut_a (
      .clk(clk), .rst(rst), .callActive(callActive), .keyValid(keyValid),
      .keyChar(keyChar), .keySide(keySide), .sendCharCaller(a_caller),
      .sendCharCallee(a_callee), .charSent(a_char), .count(a_count),
      .full(a_full), .empty(a_empty), .dropCount(a_drop));

   phone_char_feeder #(.DEPTH(4), .GAP(8)) dut_b (
      .clk(clk), .rst(rst), .callActive(callActive), .keyValid(keyValid),
      .keyChar(keyChar), .keySide(keySide), .sendCharCaller(b_caller),
      .sendCharCallee(b_callee), .charSent(b_char), .count(b_count),
      .full(b_full), .empty(b_empty), .dropCount(b_drop));

   typedef struct {
      logic        side;
      logic [7:0]  ch;
      int unsigned at;
   } exp_t;

   typedef struct {
      logic       ca;
      logic       kv;
      logic [7:0] ch;
      logic       side;
      logic       acc;
      logic [7:0] drop_inc;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[8];
   int unsigned n_checks = 0, n_fails = 0, cyc = 0, pulses_seen = 0;
   logic        mon_en = 1'b0, mon_sel = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_pulse(input logic side, input logic [7:0] ch, input int unsigned at);
      exp_t e;
      e.side = side; e.ch = ch; e.at = at;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      logic       cl, ce;
      logic [7:0] cs;
      exp_t       e;
      if (a_caller || a_callee) check("no_overlap_a", {31'd0, a_caller & a_callee}, 32'd0);
      if (b_caller || b_callee) check("no_overlap_b", {31'd0, b_caller & b_callee}, 32'd0);
      cl = mon_sel ? b_caller : a_caller;
      ce = mon_sel ? b_callee : a_callee;
      cs = mon_sel ? b_char   : a_char;
      if (mon_en && (cl || ce)) begin
         pulses_seen++;
         n_checks++;
         if (sb.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_pulse: got char %0h side %0d expected no pulse (cycle %0d)",
                     cs, ce, cyc);
         end else begin
            e = sb.pop_front();
            check("pulse_side", {31'd0, ce}, {31'd0, e.side});
            check("pulse_char", {24'd0, cs}, {24'd0, e.ch});
            if (e.at != 0) check("pulse_cycle", cyc, e.at);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      keyValid = 1'b0; keyChar = 8'h00; keySide = 1'b0;
   endtask

   task automatic ticks(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b0; callActive = 1'b0; idle_in();
      ticks(2);
      rst = 1'b1;
      sb.delete();
   endtask

   task automatic drive_key(input logic [7:0] ch, input logic side);
      keyValid = 1'b1; keyChar = ch; keySide = side;
      tick();
      idle_in();
   endtask

   initial begin : main
      int unsigned t, p0;
      logic [7:0]  d0;

      vecs[0] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 8'd0};
      vecs[1] = '{1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 8'd0};
      vecs[2] = '{1'b1, 1'b1, 8'h1F, 1'b0, 1'b0, 8'd1};
      vecs[3] = '{1'b1, 1'b1, 8'h7F, 1'b1, 1'b0, 8'd1};
      vecs[4] = '{1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 8'd1};
      vecs[5] = '{1'b0, 1'b1, 8'h78, 1'b0, 1'b0, 8'd0};
      vecs[6] = '{1'b1, 1'b0, 8'h51, 1'b0, 1'b0, 8'd0};
      vecs[7] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'd1};

      // Reset wins over a simultaneous push
      rst = 1'b0; callActive = 1'b1; keyValid = 1'b1; keyChar = 8'h5A; keySide = 1'b0;
      ticks(2);
      check("rst_count", {29'd0, a_count}, 32'd0);
      check("rst_empty", {31'd0, a_empty}, 32'd1);
      check("rst_full",  {31'd0, a_full},  32'd0);
      check("rst_drop",  {24'd0, a_drop},  32'd0);
      check("rst_char",  {24'd0, a_char},  32'd0);
      check("rst_pulses", {30'd0, a_caller, a_callee}, 32'd0);
      rst = 1'b1; idle_in(); mon_en = 1'b1; mon_sel = 1'b0;
      ticks(2);
      check("post_rst_count", {29'd0, a_count}, 32'd0);

      // Single 'H' from the caller
      t = cyc;
      expect_pulse(1'b0, 8'h48, t + 2);
      drive_key(8'h48, 1'b0);
      check("h_count_t1", {29'd0, a_count}, 32'd1);
      tick();
      check("h_caller_t2", {31'd0, a_caller}, 32'd1);
      check("h_char_t2",   {24'd0, a_char},   32'h48);
      check("h_count_t2",  {29'd0, a_count},  32'd0);
      tick();
      check("h_caller_t3", {31'd0, a_caller}, 32'd0);
      ticks(3);

      // 'A','B','C' back-to-back
      t = cyc;
      expect_pulse(1'b0, 8'h41, t + 2);
      expect_pulse(1'b0, 8'h42, t + 4);
      expect_pulse(1'b0, 8'h43, t + 6);
      drive_key(8'h41, 1'b0);
      drive_key(8'h42, 1'b0);
      drive_key(8'h43, 1'b0);
      ticks(8);
      check("abc_drained", sb.size(), 32'd0);
      check("abc_count",   {29'd0, a_count}, 32'd0);

      // Alternating sides
      t = cyc;
      expect_pulse(1'b0, 8'h61, t + 2);
      expect_pulse(1'b1, 8'h62, t + 4);
      expect_pulse(1'b0, 8'h63, t + 6);
      expect_pulse(1'b1, 8'h64, t + 8);
      drive_key(8'h61, 1'b0);
      drive_key(8'h62, 1'b1);
      drive_key(8'h63, 1'b0);
      drive_key(8'h64, 1'b1);
      ticks(10);
      check("alt_drained", sb.size(), 32'd0);

      // Printable boundaries, control chars, inactive call, no strobe
      foreach (vecs[i]) begin
         callActive = 1'b1; idle_in();
         ticks(3);
         d0 = a_drop; p0 = pulses_seen; t = cyc;
         if (vecs[i].acc) expect_pulse(vecs[i].side, vecs[i].ch, t + 2);
         callActive = vecs[i].ca; keyValid = vecs[i].kv;
         keyChar = vecs[i].ch; keySide = vecs[i].side;
         tick();
         idle_in(); callActive = 1'b1;
         ticks(4);
         check($sformatf("vec%0d_drop", i), {24'd0, 8'(a_drop - d0)}, {24'd0, vecs[i].drop_inc});
         check($sformatf("vec%0d_pulse", i), pulses_seen - p0, {31'd0, vecs[i].acc});
      end
      check("vec_drop_total", {24'd0, a_drop}, 32'd4);

      // dropCount saturates
      keyValid = 1'b1; keyChar = 8'h05;
      ticks(260);
      idle_in(); tick();
      check("drop_saturate", {24'd0, a_drop}, 32'd255);

      // GAP=8: fill during WAIT, overflow, then push+pop while full
      do_reset(); mon_sel = 1'b1; callActive = 1'b1;
      ticks(2);
      t = cyc;
      expect_pulse(1'b0, 8'h48, t + 2);
      drive_key(8'h48, 1'b0);
      tick();
      for (int k = 0; k < 6; k++) begin
         if (k < 4) expect_pulse(1'(k), 8'(8'h6B + k), t + 10 + 8 * k);
         drive_key(8'(8'h6B + k), 1'(k));
      end
      check("fill_full",  {31'd0, b_full},  32'd1);
      check("fill_count", {29'd0, b_count}, 32'd4);
      check("fill_empty", {31'd0, b_empty}, 32'd0);
      check("fill_drop",  {24'd0, b_drop},  32'd2);
      tick();
      expect_pulse(1'b0, 8'h7A, t + 42);
      drive_key(8'h7A, 1'b0);
      check("full_pushpop_count", {29'd0, b_count}, 32'd4);
      check("full_pushpop_drop",  {24'd0, b_drop},  32'd2);
      ticks(35);
      check("fill_drained", sb.size(), 32'd0);
      check("fill_end_empty", {31'd0, b_empty}, 32'd1);

      // Flush on callActive drop keeps charSent and dropCount
      do_reset(); callActive = 1'b1;
      ticks(2);
      t = cyc;
      expect_pulse(1'b0, 8'h48, t + 2);
      drive_key(8'h48, 1'b0);
      drive_key(8'h01, 1'b0);
      drive_key(8'h31, 1'b0);
      drive_key(8'h32, 1'b1);
      drive_key(8'h33, 1'b0);
      check("flush_pre_count", {29'd0, b_count}, 32'd3);
      callActive = 1'b0;
      tick();
      check("flush_count", {29'd0, b_count}, 32'd0);
      check("flush_empty", {31'd0, b_empty}, 32'd1);
      check("flush_full",  {31'd0, b_full},  32'd0);
      check("flush_char",  {24'd0, b_char},  32'h48);
      check("flush_drop",  {24'd0, b_drop},  32'd1);
      p0 = pulses_seen;
      callActive = 1'b1;
      ticks(30);
      check("flush_no_pulses", pulses_seen - p0, 32'd0);

      // Reset mid-transfer discards the queue
      t = cyc;
      expect_pulse(1'b0, 8'h51, t + 2);
      drive_key(8'h51, 1'b0);
      drive_key(8'h52, 1'b1);
      drive_key(8'h53, 1'b0);
      check("midrst_pre_count", {29'd0, b_count}, 32'd2);
      rst = 1'b0;
      tick();
      check("midrst_count", {29'd0, b_count}, 32'd0);
      check("midrst_empty", {31'd0, b_empty}, 32'd1);
      check("midrst_char",  {24'd0, b_char},  32'd0);
      check("midrst_drop",  {24'd0, b_drop},  32'd0);
      rst = 1'b1;
      p0 = pulses_seen;
      ticks(30);
      check("midrst_no_pulses", pulses_seen - p0, 32'd0);
      check("midrst_end_count", {29'd0, b_count}, 32'd0);

      check("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
